// File: rtl/raster_pkg.sv
// raster_pkg: shared constants and sequencer state type for the vertex pipeline.
// Provides screen-centre and apex constants, the cos fixed-point fraction width
// and the vert_seq state enum.
package raster_pkg;
  localparam int ANGLE_MAX = 359;
  localparam int CENTER_X = 320;
  localparam int CENTER_Y = 240;
  localparam int APEX_Y = 120;
  localparam int COS_FRAC = 10;
  typedef enum logic [2:0] {IDLE, FETCH, MUL_B, MUL_C, DONE} vseq_state_t;
endpackage

// File: rtl/smul_q10.sv
// smul_q10: combinational 9x12 signed multiply, result scaled down by the Q1.10 fraction.
// Ports: a (9-bit signed offset), b (12-bit signed Q1.10 cosine),
//        p (11-bit signed product[20:10], arithmetic floor).
module smul_q10
  import raster_pkg::*;
(
  input  logic signed [8:0]  a,
  input  logic signed [11:0] b,
  output logic signed [10:0] p
);
  logic signed [20:0] prod;
  assign prod = a * b;
  assign p = 11'(prod >>> COS_FRAC);
endmodule

// File: rtl/vert_seq.sv
// vert_seq: frame-synchronous rotated-triangle vertex sequencer.
// Ports: clk_pix/rst_n clock and async active-low reset; frame_start vblank pulse;
//        y1/y2 vertex offsets; angle -> cos ROM address, cos <- Q1.10 cosine (1-cycle ROM);
//        ax/ay/bx/by/cx/cy vertex set; out_valid/out_ready handshake; busy; drop_cnt.
module vert_seq #(
  parameter int ANGLE_MAX = raster_pkg::ANGLE_MAX,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic signed [8:0] y1,
  input  logic signed [8:0] y2,
  output logic [8:0]        angle,
  input  logic signed [11:0] cos,
  output logic [9:0]        ax,
  output logic [9:0]        ay,
  output logic [9:0]        bx,
  output logic [9:0]        by,
  output logic [9:0]        cx,
  output logic [9:0]        cy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [7:0]        drop_cnt
);
  import raster_pkg::*;
  vseq_state_t state_q, state_d;
  logic pend_q, pend_d;
  logic [8:0] angle_q, angle_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [7:0] drop_q, drop_d;
  logic signed [8:0] y1_q, y1_d, y2_q, y2_d;
  logic [9:0] bx_q, bx_d, by_q, by_d, cx_q, cx_d, cy_q, cy_d;
  logic valid_q, valid_d, busy_q, busy_d;
  logic accept, start, in_busy;
  logic signed [8:0] y_sel;
  logic signed [11:0] c_sel;
  logic signed [10:0] x;
  // One multiplier: MUL_C reuses it with y2 and the negated cosine.
  assign y_sel = (state_q == MUL_C) ? y2_q : y1_q;
  assign c_sel = (state_q == MUL_C) ? -cos : cos;
  smul_q10 u_mul (.a(y_sel), .b(c_sel), .p(x));
  always_comb begin
    in_busy = state_q != IDLE;
    accept = state_q == DONE && out_ready;
    // A new computation starts from IDLE or straight out of an accept.
    start = (!in_busy || accept) && (frame_start || pend_q);
    y1_d = start ? y1 : y1_q;
    y2_d = start ? y2 : y2_q;
    // On accept the old pending request is consumed; a coincident pulse re-arms it.
    pend_d = !in_busy ? 1'b0 : accept ? (pend_q && frame_start) : (pend_q || frame_start);
    drop_d = (in_busy && !accept && frame_start && pend_q && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    fcnt_d = !accept ? fcnt_q : (fcnt_q == 8'(FRAMES_PER_STEP - 1)) ? 8'd0 : fcnt_q + 8'd1;
    angle_d = (accept && fcnt_q == 8'(FRAMES_PER_STEP - 1)) ?
              ((angle_q == 9'(ANGLE_MAX)) ? 9'd0 : angle_q + 9'd1) : angle_q;
    bx_d = (state_q == MUL_B) ? 10'(CENTER_X + int'(x)) : bx_q;
    by_d = (state_q == MUL_B) ? 10'(CENTER_Y + int'(y1_q)) : by_q;
    cx_d = (state_q == MUL_C) ? 10'(CENTER_X + int'(x)) : cx_q;
    cy_d = (state_q == MUL_C) ? 10'(CENTER_Y + int'(y2_q)) : cy_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? FETCH : IDLE;
      FETCH:   state_d = MUL_B;
      MUL_B:   state_d = MUL_C;
      MUL_C:   state_d = DONE;
      DONE:    state_d = accept ? (start ? FETCH : IDLE) : DONE;
      default: state_d = IDLE;
    endcase
    valid_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      angle_q <= '0;
      fcnt_q <= '0;
      drop_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      angle_q <= angle_d;
      fcnt_q <= fcnt_d;
      drop_q <= drop_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
      bx_q <= bx_d;
      by_q <= by_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end
  assign angle = angle_q;
  assign ax = 10'(CENTER_X);
  assign ay = 10'(APEX_Y);
  assign bx = bx_q;
  assign by = by_q;
  assign cx = cx_q;
  assign cy = cy_q;
  assign out_valid = valid_q;
  assign busy = busy_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_vert_seq.sv
// tb_vert_seq: directed self-checking bench for vert_seq (FRAMES_PER_STEP 1 and 3 instances).
module tb_vert_seq;
  logic clk_pix = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic signed [8:0] y1 = '0, y2 = '0;
  logic signed [11:0] cos = '0;
  logic out_ready = 1'b0;
  logic [8:0] angle, angle3;
  logic [9:0] ax, ay, bx, by, cx, cy;
  logic [9:0] ax3, ay3, bx3, by3, cx3, cy3;
  logic out_valid, busy, out_valid3, busy3;
  logic [7:0] drop_cnt, drop_cnt3;
  int checks = 0;
  int errors = 0;
  int acc = 0;

  always #5 clk_pix = ~clk_pix;

  vert_seq dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame_start(frame_start), .y1(y1), .y2(y2),
    .angle(angle), .cos(cos), .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .drop_cnt(drop_cnt)
  );

  vert_seq #(.FRAMES_PER_STEP(3)) dut3 (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame_start(frame_start), .y1(y1), .y2(y2),
    .angle(angle3), .cos(cos), .ax(ax3), .ay(ay3), .bx(bx3), .by(by3), .cx(cx3), .cy(cy3),
    .out_valid(out_valid3), .out_ready(out_ready), .busy(busy3), .drop_cnt(drop_cnt3)
  );

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic signed [8:0] a, input logic signed [8:0] b);
    y1 = a;
    y2 = b;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    acc++;
  endtask

  task automatic check_set(input string tag, input int ebx, input int eby, input int ecx, input int ecy);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_bx"}, 32'(bx), 32'(ebx));
    check({tag, "_by"}, 32'(by), 32'(eby));
    check({tag, "_cx"}, 32'(cx), 32'(ecx));
    check({tag, "_cy"}, 32'(cy), 32'(ecy));
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_angle", 32'(angle), 32'd0);
    check("rst_bx", 32'(bx), 32'd0);
    check("rst_cy", 32'(cy), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("ax", 32'(ax), 32'd320);
    check("ay", 32'(ay), 32'd120);

    // basic set with cos = 1.0, including latency
    cos = 12'sd1024;
    y1 = 9'sd100;
    y2 = 9'sd100;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("lat_fetch_busy", 32'(busy), 32'd1);
    check("lat_fetch_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    check("lat_mulc_valid", 32'(out_valid), 32'd0);
    tick();
    check_set("c1024", 420, 340, 220, 340);
    accept();
    check("acc1_valid", 32'(out_valid), 32'd0);
    check("acc1_angle", 32'(angle), 32'd1);

    // half cosine, floor rounding of negative products
    cos = 12'sd512;
    frame(-9'sd60, 9'sd0);
    check_set("c512_m60", 290, 180, 320, 240);
    accept();
    frame(-9'sd1, 9'sd5);
    check_set("c512_m1", 319, 239, 317, 245);
    accept();

    // backpressure hold
    cos = 12'sd1024;
    frame(9'sd10, -9'sd20);
    check_set("hold0", 330, 250, 340, 220);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_bx", 32'(bx), 32'd330);
      check("hold_cx", 32'(cx), 32'd340);
      check("hold_angle", 32'(angle), 32'(acc % 360));
    end
    accept();
    check("hold_acc_angle", 32'(angle), 32'(acc % 360));

    // pending and drops while busy
    frame(9'sd10, 9'sd10);
    for (int i = 0; i < 3; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
    check("drop2", 32'(drop_cnt), 32'd2);
    check("pend_hold_bx", 32'(bx), 32'd330);
    check("pend_hold_cx", 32'(cx), 32'd310);
    cos = 12'sd512;
    y1 = -9'sd60;
    y2 = 9'sd0;
    accept();
    check("pend_fetch_busy", 32'(busy), 32'd1);
    check("pend_fetch_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    check("pend_mulc_valid", 32'(out_valid), 32'd0);
    tick();
    check_set("pend_set", 290, 180, 320, 240);
    for (int i = 0; i < 300; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
    check("drop_sat", 32'(drop_cnt), 32'd255);
    accept();
    check("sat_fetch_busy", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    check("sat_valid", 32'(out_valid), 32'd1);
    accept();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("angle3_mid", 32'(angle3), 32'((acc / 3) % 360));

    // angle wrap
    while (acc % 360 != 359) begin
      frame(9'sd1, 9'sd1);
      accept();
    end
    check("angle_359", 32'(angle), 32'd359);
    check("angle3_359", 32'(angle3), 32'((acc / 3) % 360));
    frame(9'sd1, 9'sd1);
    accept();
    check("angle_wrap", 32'(angle), 32'd0);
    check("angle3_wrap", 32'(angle3), 32'((acc / 3) % 360));

    // asynchronous reset during MUL_B
    cos = 12'sd1024;
    y1 = 9'sd50;
    y2 = 9'sd50;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_angle", 32'(angle), 32'd0);
    check("arst_angle3", 32'(angle3), 32'd0);
    check("arst_bx", 32'(bx), 32'd0);
    check("arst_cx", 32'(cx), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    acc = 0;
    frame(9'sd100, 9'sd100);
    check_set("post_rst", 420, 340, 220, 340);
    accept();
    check("post_rst_angle", 32'(angle), 32'd1);
    check("post_rst_angle3", 32'(angle3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
